// File: rtl/rr_timed_arbiter.sv
// rr_timed_arbiter: round-robin arbiter with an optional per-grant timer.
//
// A grant goes to the first requester found from a rotating pointer. The owner keeps the
// grant while it keeps requesting. With RR_ARB_TIMEOUT_EN defined, each port also has a
// length limit, loaded whenever that port presents a head flit. A grant is then revoked
// after limit+1 cycles, and a one-cycle timeout pulse is raised. Without the macro,
// flit_id and length are ignored and timeout stays 0.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   req          per-port request (bit i = port i)
//   flit_id      per-port flit type, port i at [i*FID_W +: FID_W]
//   length       per-port packet length, port i at [i*LEN_W +: LEN_W]
//   grant        registered one-hot grant, zero when idle
//   grant_valid  registered, high when any grant bit is set
//   grant_idx    registered index of the owner, 0 when idle
//   timeout      registered one-cycle pulse when a grant is revoked by timer expiry
module rr_timed_arbiter #(
  parameter int unsigned NPORTS  = 5,
  parameter int unsigned LEN_W   = 12,
  parameter int unsigned FID_W   = 3,
  parameter int unsigned HEAD_ID = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NPORTS-1:0]          req,
  input  logic [NPORTS*FID_W-1:0]    flit_id,
  input  logic [NPORTS*LEN_W-1:0]    length,
  output logic [NPORTS-1:0]          grant,
  output logic                       grant_valid,
  output logic [$clog2(NPORTS)-1:0]  grant_idx,
  output logic                       timeout
);

  localparam int unsigned IDX_W = $clog2(NPORTS);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e           state;
  logic [IDX_W-1:0] ptr;

  function automatic logic [IDX_W-1:0] inc_mod(input logic [IDX_W-1:0] x);
    if (x == IDX_W'(NPORTS - 1)) return '0;
    return x + 1'b1;
  endfunction

  logic             expired;
  logic             own_req;
  logic             release_grant;
  logic [IDX_W-1:0] base;
  logic [NPORTS-1:0] cand;
  logic             found;
  logic [IDX_W-1:0] win;
  logic             take;
  logic             go_idle;

  assign own_req       = req[grant_idx];
  assign release_grant = (state == StBusy) && (!own_req || expired);

  // In BUSY the search starts after the owner and the owner itself is masked out, so
  // a released owner can only regain the grant from IDLE one cycle later.
  always_comb begin
    base  = (state == StBusy) ? inc_mod(grant_idx) : ptr;
    cand  = req;
    if (state == StBusy) cand[grant_idx] = 1'b0;
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < NPORTS; k++) begin
      logic [IDX_W-1:0] qi;
      qi = IDX_W'((32'(base) + k) % NPORTS);
      if (!found && cand[qi]) begin
        found = 1'b1;
        win   = qi;
      end
    end
  end

  assign take    = found && ((state == StIdle) || release_grant);
  assign go_idle = release_grant && !found;

`ifdef RR_ARB_TIMEOUT_EN
  logic [LEN_W-1:0] limit [NPORTS];
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] active_limit;

  assign expired = (count == active_limit);

  // Limits track head flits on every port regardless of who owns the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NPORTS; i++) limit[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NPORTS; i++) begin
        if (flit_id[i*FID_W +: FID_W] == FID_W'(HEAD_ID)) begin
          limit[i] <= length[i*LEN_W +: LEN_W];
        end
      end
    end
  end
`else
  logic unused_inputs;

  assign expired       = 1'b0;
  assign unused_inputs = ^{flit_id, length, 32'(HEAD_ID)};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= StIdle;
      grant        <= '0;
      grant_valid  <= 1'b0;
      grant_idx    <= '0;
      timeout      <= 1'b0;
      ptr          <= '0;
`ifdef RR_ARB_TIMEOUT_EN
      count        <= '0;
      active_limit <= '0;
`endif
    end else begin
      // Pulse only when the timer, not the owner dropping req, ended the grant.
      timeout <= release_grant && expired && own_req;
      if (take) begin
        state       <= StBusy;
        grant       <= {{(NPORTS-1){1'b0}}, 1'b1} << win;
        grant_valid <= 1'b1;
        grant_idx   <= win;
        ptr         <= inc_mod(win);
`ifdef RR_ARB_TIMEOUT_EN
        count        <= '0;
        active_limit <= limit[win];
`endif
      end else if (go_idle) begin
        state       <= StIdle;
        grant       <= '0;
        grant_valid <= 1'b0;
        grant_idx   <= '0;
      end else if (state == StBusy) begin
`ifdef RR_ARB_TIMEOUT_EN
        count <= count + 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_rr_timed_arbiter.sv
// Bench for rr_timed_arbiter (default parameters). Checks a fixed vector table,
// directed multi-cycle sequences for the configured build, and randomized traffic
// against a behavioural reference model.
module tb_rr_timed_arbiter;

  localparam int NP   = 5;
  localparam int LW   = 12;
  localparam int FW   = 3;
  localparam int HEAD = 1;
`ifdef RR_ARB_TIMEOUT_EN
  localparam bit TimerEn = 1'b1;
`else
  localparam bit TimerEn = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic [NP-1:0]   req;
  logic [NP*FW-1:0] flit_id;
  logic [NP*LW-1:0] length;
  logic [NP-1:0]   grant;
  logic            grant_valid;
  logic [2:0]      grant_idx;
  logic            timeout;

  int n_total = 0;
  int n_bad   = 0;

  rr_timed_arbiter #(
    .NPORTS (NP),
    .LEN_W  (LW),
    .FID_W  (FW),
    .HEAD_ID(HEAD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .flit_id    (flit_id),
    .length     (length),
    .grant      (grant),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: owner is -1 when idle.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;
  int m_alim  = 0;
  int m_lim [NP];
  bit m_tout  = 1'b0;

  task automatic model_step();
    int nl [NP];
    int q;
    int j;
    bit fire;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_alim = 0; m_tout = 1'b0;
      for (int i = 0; i < NP; i++) m_lim[i] = 0;
      return;
    end
    for (int i = 0; i < NP; i++)
      nl[i] = (TimerEn && flit_id[i*FW +: FW] == 3'(HEAD)) ? int'(length[i*LW +: LW]) : m_lim[i];
    m_tout = 1'b0;
    q = -1;
    if (m_owner < 0) begin
      for (int k = 0; k < NP; k++) begin
        j = (m_ptr + k) % NP;
        if (q < 0 && req[j]) q = j;
      end
    end else begin
      fire = TimerEn && (m_cnt == m_alim);
      if (req[m_owner] && !fire) begin
        m_cnt++;
      end else begin
        m_tout = fire && req[m_owner];
        for (int k = 1; k < NP; k++) begin
          j = (m_owner + k) % NP;
          if (q < 0 && req[j]) q = j;
        end
        if (q < 0) m_owner = -1;
      end
    end
    if (q >= 0) begin
      m_owner = q;
      m_ptr   = (q + 1) % NP;
      m_cnt   = 0;
      m_alim  = m_lim[q];
    end
    for (int i = 0; i < NP; i++) m_lim[i] = nl[i];
  endtask

  function automatic logic [2:0] idx_of(input logic [NP-1:0] g);
    for (int i = 0; i < NP; i++) if (g[i]) return 3'(i);
    return 3'd0;
  endfunction

  task automatic check(input string name, input logic [NP-1:0] eg, input bit et);
    n_total++;
    if ({grant, grant_valid, grant_idx, timeout} !== {eg, |eg, idx_of(eg), et}) begin
      n_bad++;
      $display("FAIL %s: got grant=%b valid=%b idx=%0d timeout=%b, want grant=%b valid=%b idx=%0d timeout=%b",
               name, grant, grant_valid, grant_idx, timeout, eg, |eg, idx_of(eg), et);
    end
  endtask

  task automatic apply(input bit r, input logic [NP-1:0] rq, input logic [NP*FW-1:0] f,
                       input logic [NP*LW-1:0] l);
    rst = r; req = rq; flit_id = f; length = l;
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NP*FW-1:0] hd(input int p);
    return (NP*FW)'(HEAD) << (p * FW);
  endfunction

  function automatic logic [NP*LW-1:0] ln(input int p, input int v);
    return (NP*LW)'(v) << (p * LW);
  endfunction

  typedef struct {
    bit            r;
    logic [NP-1:0] rq;
    logic [NP-1:0] eg;
  } vec_t;

  vec_t             tbl [19];
  logic [NP*FW-1:0] all_head;
  logic [NP*LW-1:0] all_len;
  logic [NP*FW-1:0] rf;
  logic [NP*LW-1:0] rl;
  logic [NP-1:0]    rr;

  initial begin
    // Limits are kept at 100 during the table so it holds for either build.
    tbl[0]  = '{1'b1, 5'b00000, 5'b00000};
    tbl[1]  = '{1'b0, 5'b00000, 5'b00000};
    tbl[2]  = '{1'b0, 5'b00001, 5'b00001};
    tbl[3]  = '{1'b0, 5'b00001, 5'b00001};
    tbl[4]  = '{1'b0, 5'b00000, 5'b00000};
    tbl[5]  = '{1'b0, 5'b00011, 5'b00010};
    tbl[6]  = '{1'b0, 5'b00011, 5'b00010};
    tbl[7]  = '{1'b0, 5'b00001, 5'b00001};
    tbl[8]  = '{1'b0, 5'b10001, 5'b00001};
    tbl[9]  = '{1'b0, 5'b10000, 5'b10000};
    tbl[10] = '{1'b0, 5'b00000, 5'b00000};
    tbl[11] = '{1'b0, 5'b01100, 5'b00100};
    tbl[12] = '{1'b0, 5'b01000, 5'b01000};
    tbl[13] = '{1'b1, 5'b01000, 5'b00000};
    tbl[14] = '{1'b0, 5'b00000, 5'b00000};
    tbl[15] = '{1'b0, 5'b11000, 5'b01000};
    tbl[16] = '{1'b0, 5'b11000, 5'b01000};
    tbl[17] = '{1'b0, 5'b10000, 5'b10000};
    tbl[18] = '{1'b0, 5'b00000, 5'b00000};
    all_head = '0;
    all_len  = '0;
    for (int i = 0; i < NP; i++) begin
      all_head |= hd(i);
      all_len  |= ln(i, 100);
    end

    rst = 1'b1; req = '0; flit_id = '0; length = '0;
    for (int i = 0; i < 19; i++) begin
      apply(tbl[i].r, tbl[i].rq, all_head, all_len);
      check($sformatf("table[%0d]", i), tbl[i].eg, 1'b0);
    end

`ifdef RR_ARB_TIMEOUT_EN
    // Single requester, limit 3: four-cycle grant, pulse, idle, re-grant.
    apply(1, '0, '0, '0);               check("r31_rst", 5'b0, 0);
    apply(0, '0, hd(0), ln(0, 3));      check("r31_load", 5'b0, 0);
    for (int i = 0; i < 4; i++) begin
      apply(0, 5'b00001, '0, '0);       check("r31_hold", 5'b00001, 0);
    end
    apply(0, 5'b00001, '0, '0);         check("r31_tout", 5'b00000, 1);
    apply(0, 5'b00001, '0, '0);         check("r31_regrant", 5'b00001, 0);

    // All requesting with zero limits: one port per cycle.
    apply(1, '0, '0, '0);               check("r32_rst", 5'b0, 0);
    for (int i = 0; i < 6; i++) begin
      apply(0, 5'b11111, '0, '0);       check("r32_rot", 5'(1 << (i % NP)), i > 0);
    end

    // Owner drops before expiry: hand-off without a pulse.
    apply(1, '0, '0, '0);               check("r33_rst", 5'b0, 0);
    apply(0, '0, hd(2), ln(2, 10));     check("r33_load", 5'b0, 0);
    apply(0, 5'b00100, '0, '0);         check("r33_g1", 5'b00100, 0);
    apply(0, 5'b00100, '0, '0);         check("r33_g2", 5'b00100, 0);
    apply(0, 5'b10000, '0, '0);         check("r33_move", 5'b10000, 0);

    // Head flit mid-grant affects only the next grant.
    apply(1, '0, '0, '0);               check("r34_rst", 5'b0, 0);
    apply(0, '0, hd(1), ln(1, 5));      check("r34_load", 5'b0, 0);
    apply(0, 5'b00010, '0, '0);         check("r34_c1", 5'b00010, 0);
    apply(0, 5'b00010, hd(1), ln(1, 1)); check("r34_c2", 5'b00010, 0);
    for (int i = 0; i < 4; i++) begin
      apply(0, 5'b00010, '0, '0);       check("r34_hold", 5'b00010, 0);
    end
    apply(0, 5'b00010, '0, '0);         check("r34_tout1", 5'b00000, 1);
    apply(0, 5'b00010, '0, '0);         check("r34_n1", 5'b00010, 0);
    apply(0, 5'b00010, '0, '0);         check("r34_n2", 5'b00010, 0);
    apply(0, 5'b00010, '0, '0);         check("r34_tout2", 5'b00000, 1);

    // Reset during a grant clears the pointer.
    apply(1, '0, '0, '0);               check("r35_rst", 5'b0, 0);
    apply(0, '0, hd(3), ln(3, 10));     check("r35_load", 5'b0, 0);
    apply(0, 5'b01000, '0, '0);         check("r35_g1", 5'b01000, 0);
    apply(0, 5'b01000, '0, '0);         check("r35_g2", 5'b01000, 0);
    apply(1, 5'b01000, '0, '0);         check("r35_midrst", 5'b00000, 0);
    apply(0, 5'b11000, '0, '0);         check("r35_first", 5'b01000, 0);
`else
    // No timer: grant is held for as long as req stays high.
    apply(1, '0, '0, '0);               check("r36_rst", 5'b0, 0);
    for (int i = 0; i < 50; i++) begin
      apply(0, 5'b00001, hd(0), ln(0, 2)); check("r36_hold", 5'b00001, 0);
    end
`endif

    // Randomized traffic against the model.
    apply(1, '0, '0, '0);
    check("rand_rst", 5'b0, 0);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NP; i++) begin
        rr[i] = ($urandom_range(0, 9) < 7);
        rf[i*FW +: FW] = ($urandom_range(0, 3) == 0) ? 3'(HEAD) : 3'($urandom_range(2, 7));
        rl[i*LW +: LW] = 12'($urandom_range(0, 6));
      end
      apply($urandom_range(0, 299) == 0, rr, rf, rl);
      check("rand", (m_owner < 0) ? 5'b0 : 5'(1 << m_owner), m_tout);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_timed_arbiter.md
RR_TIMED_ARBITER -- requirements
Module: rr_timed_arbiter

Interface
REQ-001 SHALL have parameter NPORTS, default 5: number of requesting ports, 2..16.
REQ-002 SHALL have parameter LEN_W, default 12: width of each per-port length/timeout value.
REQ-003 SHALL have parameter FID_W, default 3: width of each per-port flit_id.
REQ-004 SHALL have parameter HEAD_ID, default 1: flit_id value identifying a head flit.
REQ-005 SHALL have port clk, input, 1: clock, all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port req, input, NPORTS: per-port request, bit i = port i.
REQ-008 SHALL have port flit_id, input, NPORTS*FID_W: per-port flit type, port i at bits [i*FID_W +: FID_W].
REQ-009 SHALL have port length, input, NPORTS*LEN_W: per-port packet length, port i at [i*LEN_W +: LEN_W].
REQ-010 SHALL have port grant, output, NPORTS: registered one-hot grant, all-zero when idle.
REQ-011 SHALL have port grant_valid, output, 1: registered, high when any grant bit is high.
REQ-012 SHALL have port grant_idx, output, $clog2(NPORTS): registered index of the granted port, 0 when idle.
REQ-013 SHALL have port timeout, output, 1: registered one-cycle pulse when a grant is revoked by timer expiry.

Function
REQ-014 SHALL implement two states: IDLE (grant=0) and BUSY (exactly one grant bit set, owner p).
REQ-015 SHALL keep a round-robin pointer ptr; in IDLE, grant the first requester found searching ptr, ptr+1, ... modulo NPORTS, or stay IDLE if req=0.
REQ-016 SHALL present a new grant on the clock edge after the request that wins it is sampled (1-cycle latency).
REQ-017 SHALL set ptr to (p+1) mod NPORTS on every edge where port p becomes owner.
REQ-018 SHALL, in BUSY, hold the grant while req[p]=1 and the owner timer has not expired.
REQ-019 SHALL, on release in BUSY, grant the first requester searching p+1 ... p+NPORTS-1 modulo NPORTS, excluding p; if none, go IDLE (p may regain the grant one cycle later from IDLE).
REQ-020 SHALL, per port, load limit[i] <= length[i] on any cycle where flit_id[i]==HEAD_ID, independent of grant state; the new value is visible the following cycle.
REQ-021 SHALL snapshot the owner's limit into active_limit and clear count to 0 on the grant-taking edge.
REQ-022 SHALL, each BUSY cycle, treat the timer as expired when count==active_limit; otherwise increment count (LEN_W bits, no wrap possible before match).
REQ-023 SHALL thereby hold a continuously requesting owner for exactly active_limit+1 cycles; active_limit=0 gives a one-cycle grant.
REQ-024 SHALL assert timeout for one cycle, coincident with the first cycle after release, only when release was caused by expiry with req[p] still 1.
REQ-025 SHALL not reload active_limit mid-grant when the owner sends another head flit; limit[p] updates only for the next grant.
REQ-026 SHALL keep grant, grant_valid and grant_idx mutually consistent every cycle.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, clear grant, grant_valid, grant_idx, timeout, ptr, count, active_limit and all limit[i] to 0 and enter IDLE, overriding any in-progress grant.
REQ-028 SHALL issue no grant on the first edge after rst deasserts unless req was sampled high on that edge.

Configuration
REQ-029 SHALL, with macro RR_ARB_TIMEOUT_EN defined, implement the timer behaviour of REQ-020..REQ-025.
REQ-030 SHALL, without RR_ARB_TIMEOUT_EN, omit limit/count logic, hold a grant until req[p] drops, ignore flit_id and length, and tie timeout to 0.

Verification
REQ-031 SHALL cover: rst, then req=5'b00001 held, length[0]=3 with head flit -> grant=00001 for 4 cycles, timeout pulse, 1 idle cycle, re-grant port 0.
REQ-032 SHALL cover: req=5'b11111 held, all limits 0 -> grant rotates 0,1,2,3,4,0 one port per cycle, timeout pulsing each cycle.
REQ-033 SHALL cover: owner port 2 drops req after 2 cycles with limit 10, req[4]=1 -> grant moves to 4 next cycle, no timeout pulse.
REQ-034 SHALL cover: owner port 1 with limit 5 receives head flit length 1 mid-grant -> current grant lasts 6 cycles; next port-1 grant lasts 2 cycles.
REQ-035 SHALL cover: rst asserted during BUSY on port 3 -> grant=0, grant_idx=0, ptr=0 the next cycle; then req=5'b11000 -> port 3 granted first.
REQ-036 SHALL cover: build without RR_ARB_TIMEOUT_EN, req[0] held 50 cycles with length[0]=2 -> grant=00001 for all 50 cycles, timeout never asserts.
